// File: rtl/tdc_pulse_gen.sv
// tdc_pulse_gen: burst generator of START/STOP edge pairs for exercising a
// time-to-digital converter. Each shot drives start_o, then stop_o a
// programmable number of clk cycles later; shots within a burst are separated
// by GAP idle cycles. done pulses once after the final shot.
//
// Optional feature: define TDC_PULSE_GEN_SWEEP_EN to make the latched interval
// grow by one cycle after every shot (saturating), giving a linearity sweep.
//
// Request semantics: trig is a level request with no ready signal. It is
// accepted only on an edge where the FSM is in IDLE and ena is high; busy high
// means any trig is ignored. Interval and burst are captured on that same edge.
module tdc_pulse_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4,
  parameter int GAP     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               trig,
  input  logic [CNT_W-1:0]   interval,
  input  logic [BURST_W-1:0] burst,
  output logic               start_o,
  output logic               stop_o,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] shot_cnt
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  // The state names the phase of the current cycle: START is the cycle
  // carrying start_o, WAIT counts toward stop_o (and holds the stop cycle
  // itself), GAPW is the inter-shot gap, FIN is the done cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    GAPW  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   iv_q, iv_n;        // latched start-to-stop interval
  logic [CNT_W-1:0]   cnt_q, cnt_n;      // cycles remaining until stop_o
  logic [BURST_W-1:0] shots_q, shots_n;  // latched shot count (0 mapped to 1)
  logic [BURST_W-1:0] shot_n;
  logic [GAP_W-1:0]   gap_q, gap_n;      // gap cycles remaining after this one
  logic               start_n, stop_n, busy_n, done_n;

  logic               launch;            // begin a shot on this edge
  logic [CNT_W-1:0]   launch_iv;
  logic               after_stop;        // the current cycle carries stop_o
  logic [BURST_W:0]   next_shot_w;
  logic               last_shot;
  logic [CNT_W-1:0]   iv_step;           // interval to use for the next shot

  assign next_shot_w = {1'b0, shot_cnt} + {{BURST_W{1'b0}}, 1'b1};
  assign last_shot   = next_shot_w >= {1'b0, shots_q};

`ifdef TDC_PULSE_GEN_SWEEP_EN
  // Sweep: one more cycle per shot, held at the counter maximum.
  assign iv_step = (&iv_q) ? iv_q : iv_q + CNT_W'(1);
`else
  assign iv_step = iv_q;
`endif

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n    = state;
    iv_n       = iv_q;
    cnt_n      = cnt_q;
    shots_n    = shots_q;
    shot_n     = shot_cnt;
    gap_n      = gap_q;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    launch     = 1'b0;
    launch_iv  = '0;
    after_stop = 1'b0;

    unique case (state)
      IDLE: begin
        if (trig) begin
          launch    = 1'b1;
          launch_iv = interval;
          iv_n      = interval;
          shots_n   = (burst == '0) ? BURST_W'(1) : burst;
          shot_n    = '0;
        end
      end
      START, WAIT: begin
        if (stop_o) begin
          after_stop = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = cnt_q - CNT_W'(1);
          stop_n  = (cnt_q == CNT_W'(1));
          busy_n  = 1'b1;
        end
      end
      GAPW: begin
        busy_n = 1'b1;
        if (gap_q == '0) begin
          launch    = 1'b1;
          launch_iv = iv_q;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Close out a shot: count it, then finish, gap, or fire the next one.
    if (after_stop) begin
      shot_n = next_shot_w[BURST_W-1:0];
      iv_n   = iv_step;
      busy_n = 1'b1;
      if (last_shot) begin
        state_n = FIN;
        done_n  = 1'b1;
      end else if (GAP == 0) begin
        launch    = 1'b1;
        launch_iv = iv_step;
      end else begin
        state_n = GAPW;
        gap_n   = GAP_LOAD;
      end
    end

    // Fire a shot: start_o now, stop_o too when the interval is zero.
    if (launch) begin
      state_n = START;
      start_n = 1'b1;
      stop_n  = (launch_iv == '0);
      cnt_n   = launch_iv;
      busy_n  = 1'b1;
    end

    // Disable wins over everything; shot_cnt and latches keep their values.
    if (!ena) begin
      state_n = IDLE;
      start_n = 1'b0;
      stop_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      shot_n  = shot_cnt;
      iv_n    = iv_q;
      shots_n = shots_q;
      cnt_n   = cnt_q;
      gap_n   = gap_q;
    end
  end

  // State, counters, latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iv_q     <= '0;
      cnt_q    <= '0;
      shots_q  <= '0;
      gap_q    <= '0;
      shot_cnt <= '0;
      start_o  <= 1'b0;
      stop_o   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      iv_q     <= iv_n;
      cnt_q    <= cnt_n;
      shots_q  <= shots_n;
      gap_q    <= gap_n;
      shot_cnt <= shot_n;
      start_o  <= start_n;
      stop_o   <= stop_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Testbench for tdc_pulse_gen: a cycle table for the basic single shot, a
// randomized run against a schedule-based reference model, and hand-written
// sequences for zero interval, held trig, ena abort, reset abort and the
// interval sweep (TDC_PULSE_GEN_SWEEP_EN).
module tb_tdc_pulse_gen;

  localparam int CNT_W   = 8;
  localparam int BURST_W = 4;
  localparam int GAP     = 16;
  localparam int NC      = 8192;
  localparam int IV_MAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               trig;
  logic [CNT_W-1:0]   interval;
  logic [BURST_W-1:0] burst;
  logic               start_o, stop_o, busy, done;
  logic [BURST_W-1:0] shot_cnt;

  always #5 clk = ~clk;

  tdc_pulse_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .trig     (trig),
    .interval (interval),
    .burst    (burst),
    .start_o  (start_o),
    .stop_o   (stop_o),
    .busy     (busy),
    .done     (done),
    .shot_cnt (shot_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // index of the clock edge; period x follows edge x

  // Expected waveform schedule, one slot per period index.
  bit m_start[NC];
  bit m_stop[NC];
  bit m_busy[NC];
  bit m_done[NC];
  bit m_clr[NC];    // shot count restarts at 0 in this period
  bit m_inc[NC];    // shot count is one higher from this period on
  int idle_idx;     // first period index in which the FSM is idle
  int shot_m;

  // Observed/expected start-to-stop spacings and event counters.
  logic [CNT_W:0] exp_q[$];
  logic [CNT_W:0] obs_q[$];
  int st_q[$];
  int last_start = 0;
  int n_coinc, n_done, n_stop;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_clear(int from);
    for (int x = from; x < NC; x++) begin
      if (x >= 0) begin
        m_start[x] = 0; m_stop[x] = 0; m_busy[x] = 0;
        m_done[x]  = 0; m_clr[x]  = 0; m_inc[x]  = 0;
      end
    end
  endfunction

  function automatic void mark_busy(int a, int b);
    for (int x = a; x <= b; x++) if (x < NC) m_busy[x] = 1;
  endfunction

  // Burst accepted at edge e: shot k starts at s_k, stops iv_k later, the next
  // shot starts GAP+1 after that stop; done follows the last stop.
  function automatic void model_burst(int e, int iv, int b);
    int n, s, p, ivk;
    n = (b == 0) ? 1 : b;
    s = e;
    if (s < NC) m_clr[s] = 1;
    for (int k = 0; k < n; k++) begin
      ivk = iv;
`ifdef TDC_PULSE_GEN_SWEEP_EN
      ivk = (iv + k > IV_MAX) ? IV_MAX : iv + k;
`endif
      p = s + ivk;
      if (s < NC) m_start[s] = 1;
      if (p < NC) m_stop[p] = 1;
      if (p + 1 < NC) m_inc[p + 1] = 1;
      mark_busy(s, p);
      if (k == n - 1) begin
        if (p + 1 < NC) m_done[p + 1] = 1;
        mark_busy(p + 1, p + 1);
        idle_idx = p + 2;
      end else begin
        mark_busy(p + 1, p + GAP);
        s = p + GAP + 1;
      end
    end
  endfunction

  function automatic void model_step(int e);
    if (!rst_n) return;
    if (!ena) begin
      model_clear(e);
      idle_idx = e;
    end else if (trig && (e - 1 >= idle_idx)) begin
      model_burst(e, int'(interval), int'(burst));
    end
  endfunction

  function automatic void check_model(int e);
    if (e < NC) begin
      if (m_clr[e]) shot_m = 0;
      if (m_inc[e]) shot_m++;
      chk("start_o", start_o, m_start[e]);
      chk("stop_o", stop_o, m_stop[e]);
      chk("busy", busy, m_busy[e]);
      chk("done", done, m_done[e]);
      chk("shot_cnt", shot_cnt, shot_m);
    end
    if (start_o) begin
      last_start = e;
      st_q.push_back(e);
    end
    if (stop_o) begin
      obs_q.push_back((CNT_W+1)'(e - last_start));
      n_stop++;
    end
    if (start_o && stop_o) n_coinc++;
    if (done) n_done++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input bit en, input bit tr, input int iv, input int b);
    ena      = en;
    trig     = tr;
    interval = CNT_W'(iv);
    burst    = BURST_W'(b);
    @(posedge clk);
    model_step(cyc);
    @(negedge clk);
    check_model(cyc);
    cyc++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_start_o", start_o, 0);
    chk("rst_stop_o", stop_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shot_cnt", shot_cnt, 0);
    model_clear(cyc);
    shot_m   = 0;
    idle_idx = -1;
    repeat (2) run_cycle(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    st_q.delete();
    n_coinc = 0;
    n_done  = 0;
    n_stop  = 0;
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    bit ena;
    bit trig;
    int iv;
    int b;
    bit e_start;
    bit e_stop;
    bit e_busy;
    bit e_done;
    int e_shot;
  } vec_t;

  vec_t tbl[9];

  task automatic apply_row(input vec_t r, input int idx);
    ena      = r.ena;
    trig     = r.trig;
    interval = CNT_W'(r.iv);
    burst    = BURST_W'(r.b);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("tbl%0d_start_o", idx), start_o, r.e_start);
    chk($sformatf("tbl%0d_stop_o", idx), stop_o, r.e_stop);
    chk($sformatf("tbl%0d_busy", idx), busy, r.e_busy);
    chk($sformatf("tbl%0d_done", idx), done, r.e_done);
    chk($sformatf("tbl%0d_shot_cnt", idx), shot_cnt, r.e_shot);
    cyc++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Single shot, interval 5: start, four waits, stop, done, idle. Trig and
    // new operands offered during the burst must be ignored.
    tbl[0] = '{1'b1, 1'b1, 5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[7] = '{1'b1, 1'b1, 9, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[8] = '{1'b1, 1'b0, 9, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0; ena = 1'b0; trig = 1'b0; interval = '0; burst = '0;
    clear_obs();
    shot_m = 0;
    idle_idx = -1;
    #1;
    chk("init_start_o", start_o, 0);
    chk("init_stop_o", stop_o, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_shot_cnt", shot_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_row(tbl[i], i);

    // Randomized traffic with occasional ena drops.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      run_cycle($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) < 3,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6),
                $urandom_range(0, 3));
    end

    // Zero interval, three shots: coincident edges 17 cycles apart.
    do_reset();
    clear_obs();
    run_cycle(1, 1, 0, 3);
    repeat (60) run_cycle(1, 0, 7, 9);
    chk("zero_iv_coincident", n_coinc, 3);
    chk("zero_iv_done", n_done, 1);
    chk("zero_iv_shot_cnt", shot_cnt, 3);
    if (st_q.size() == 3) begin
      chk("zero_iv_spacing_1", st_q[1] - st_q[0], GAP + 1);
      chk("zero_iv_spacing_2", st_q[2] - st_q[1], GAP + 1);
    end else begin
      chk("zero_iv_starts", st_q.size(), 3);
    end

    // Trig held with burst 0: one shot per burst, restart right after idle.
    do_reset();
    clear_obs();
    repeat (80) run_cycle(1, 1, 2, 0);
    chk("held_trig_bursts", n_done, 16);
    chk("held_trig_stops", n_stop, 16);

    // Drop ena in WAIT of the second shot of a 4-shot burst.
    do_reset();
    clear_obs();
    run_cycle(1, 1, 6, 4);
    repeat (25) run_cycle(1, 0, 6, 4);
    chk("abort_busy_before", busy, 1);
    run_cycle(0, 0, 6, 4);
    chk("abort_busy", busy, 0);
    chk("abort_shot_frozen", shot_cnt, 1);
    n_stop = 0;
    n_done = 0;
    repeat (5) run_cycle(0, 1, 6, 4);
    repeat (10) run_cycle(1, 0, 6, 4);
    chk("abort_no_stop", n_stop, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_shot_held", shot_cnt, 1);

    // Reset in the gap, then a fresh single shot.
    do_reset();
    run_cycle(1, 1, 0, 3);
    repeat (5) run_cycle(1, 0, 0, 3);
    chk("gap_busy_before_reset", busy, 1);
    do_reset();
    clear_obs();
    run_cycle(1, 1, 5, 1);
    repeat (9) run_cycle(1, 0, 5, 1);
    chk("post_reset_done", n_done, 1);
    chk("post_reset_shot_cnt", shot_cnt, 1);
    if (obs_q.size() == 1) chk("post_reset_spacing", obs_q[0], 5);
    else chk("post_reset_stops", obs_q.size(), 1);

    // Long intervals near the counter limit.
    do_reset();
    clear_obs();
    exp_q.push_back((CNT_W+1)'(254));
`ifdef TDC_PULSE_GEN_SWEEP_EN
    exp_q.push_back((CNT_W+1)'(255));
    exp_q.push_back((CNT_W+1)'(255));
`else
    exp_q.push_back((CNT_W+1)'(254));
    exp_q.push_back((CNT_W+1)'(254));
`endif
    run_cycle(1, 1, 254, 3);
    repeat (3 * 256 + 2 * GAP + 10) run_cycle(1, 0, 3, 1);
    chk("sweep_stop_count", obs_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size()) chk($sformatf("sweep_spacing_%0d", i), obs_q[i], exp_q[i]);
    end
    chk("sweep_shot_cnt", shot_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_pulse_gen.md
TDC_PULSE_GEN -- requirements
Module: tdc_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the start-to-stop interval in clk cycles.
REQ-002 SHALL have parameter BURST_W, default 4, width of the shot-count fields.
REQ-003 SHALL have parameter GAP, default 16, number of idle cycles between a stop_o pulse and the next start_o pulse in a burst.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ena  input  1  block enable; low aborts activity.
REQ-007 SHALL have port trig  input  1  burst request, sampled each cycle.
REQ-008 SHALL have port interval  input  CNT_W  start-to-stop spacing in cycles.
REQ-009 SHALL have port burst  input  BURST_W  number of shots per burst.
REQ-010 SHALL have port start_o  output  1  one-cycle START edge for the TDC under test.
REQ-011 SHALL have port stop_o  output  1  one-cycle STOP edge for the TDC under test.
REQ-012 SHALL have port busy  output  1  high while a burst is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final shot of a burst.
REQ-014 SHALL have port shot_cnt  output  BURST_W  number of shots completed in the current or last burst.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, GAPW and FIN, with all outputs registered.
REQ-016 IDLE: with ena=1 and trig=1 at edge T, SHALL latch interval and burst, clear shot_cnt, and enter START; start_o and busy SHALL be high in cycle T+1.
REQ-017 A latched burst value of 0 SHALL be treated as 1.
REQ-018 stop_o SHALL be high exactly interval cycles after start_o, i.e. in cycle T+1+interval (WAIT counts down).
REQ-019 interval=0 SHALL assert start_o and stop_o in the same cycle.
REQ-020 Each stop_o cycle SHALL increment shot_cnt; the new value SHALL be visible in the following cycle.
REQ-021 If shots remain after a stop_o, the FSM SHALL enter GAPW for GAP cycles, then issue the next start_o in cycle stop+GAP+1.
REQ-022 After the last stop_o, the FSM SHALL enter FIN in the next cycle and assert done for one cycle with busy still high, then return to IDLE with busy low.
REQ-023 trig SHALL be ignored in every state other than IDLE; changes to interval or burst during a burst SHALL have no effect.
REQ-024 A trig held high SHALL start a new burst on the first cycle the FSM is back in IDLE.
REQ-025 The internal interval counter SHALL be CNT_W bits wide with no wrap; the maximum interval is 2^CNT_W-1.
REQ-026 ena=0 in any state SHALL force IDLE on the next edge with start_o, stop_o, busy and done low and no done pulse; shot_cnt SHALL hold its value.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set start_o=0, stop_o=0, busy=0, done=0 and shot_cnt=0, together with all internal counters and latches.
REQ-028 Reset deassertion SHALL take effect on the next clk edge; reset asserted mid-burst SHALL abort it with no done pulse.

Configuration
REQ-029 With macro TDC_PULSE_GEN_SWEEP_EN defined, the latched interval SHALL increment by 1 after each shot, saturating at 2^CNT_W-1, to produce a linearity sweep.
REQ-030 With TDC_PULSE_GEN_SWEEP_EN undefined, every shot in a burst SHALL use the same latched interval, and no sweep logic SHALL be present.

Verification
REQ-031 Reset then trig at edge T with interval=5 and burst=1 SHALL give start_o at T+1, stop_o at T+6, done at T+7, busy high T+1..T+7, and shot_cnt=1.
REQ-032 interval=0 and burst=3 with GAP=16 SHALL give start_o and stop_o coincident three times, 17 cycles apart, then done, with shot_cnt=3.
REQ-033 Holding trig high with burst=0 SHALL give exactly one shot per burst, and back-to-back bursts SHALL start the cycle after busy falls.
REQ-034 Dropping ena mid-WAIT of a 4-shot burst SHALL give no stop_o, no done and busy low next cycle, with shot_cnt frozen.
REQ-035 Asserting rst_n low mid-GAPW SHALL immediately clear all outputs, and a new trig after release SHALL behave as in REQ-031.
REQ-036 With TDC_PULSE_GEN_SWEEP_EN defined, interval=254 and burst=3 SHALL give start-to-stop spacings of 254, 255 and 255; with it undefined, the spacings SHALL be 254, 254 and 254.
